sram_tag_data_array: RTL
========================

// Module: sram_tag_data_array
// PURPOSE
//   Parametrised tag+data storage array for the cache datapath, addressed by a
//   one-hot wordline from the row decoder. Adds per-entry valid bits, a
//   registered read port with tag-compare hit, write-through echo, one-hot
//   wordline checking and a sequenced flush (invalidate-all) engine.
//   Sits between the row decoder and the cache hit/miss control logic.
// PARAMETERS
//   DEPTH   16  number of entries (= wordline width), >= 2
//   DATA_W  8   data field width per entry
//   TAG_W   4   tag field width per entry
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous reset, active low
//   req        in   1       access request, sampled on rising edge of clk
//   we         in   1       1 = write, 0 = read (qualified by req)
//   wl         in   DEPTH   wordline select, must be exactly one-hot
//   tag_in     in   TAG_W   write tag / read compare tag
//   data_in    in   DATA_W  write data
//   flush      in   1       start invalidate-all sequence
//   busy       out  1       flush in progress, requests are ignored
//   rd_valid   out  1       response valid, 1-cycle pulse per accepted req
//   tag_out    out  TAG_W   stored (or written) tag
//   data_out   out  DATA_W  stored (or written) data
//   valid_out  out  1       valid bit of the addressed entry
//   hit        out  1       valid_out && stored tag == request tag_in
//   wl_err     out  1       accepted req had a non-one-hot wl (0 or >1 bits set)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, all valid bits=0, flush counter=0,
//   every output=0. Tag/data storage is not reset.
//   States: IDLE, FLUSH.
//   IDLE, flush=1: enter FLUSH next edge. flush has priority over req in the
//     same cycle; that req is dropped (no response).
//   IDLE, flush=0, req=1: request accepted. Response one cycle later
//     (latency 1): rd_valid=1 for exactly one cycle.
//     - wl not one-hot: no array/valid change; response has wl_err=1,
//       tag_out=data_out=0, valid_out=0, hit=0.
//     - write (we=1): entry[idx] <= {tag_in,data_in}, valid[idx] <= 1.
//       Response echoes tag_in/data_in, valid_out=1, hit=1.
//     - read (we=0): response = stored tag/data of entry idx,
//       valid_out=valid[idx], hit = valid[idx] && (stored tag == tag_in
//       sampled with the request).
//   Back-to-back requests are accepted every cycle; a read directly after a
//   write to the same entry returns the new contents.
//   FLUSH: busy=1. Counter walks idx 0..DEPTH-1, clearing one valid bit per
//     cycle; after clearing DEPTH-1 (DEPTH cycles total) returns to IDLE and
//     busy drops the following cycle. req and flush are ignored while busy
//     (no write, no response). Tag/data contents are left unchanged.
//   When rd_valid=0: tag_out, data_out, valid_out, hit, wl_err are all 0.
//   Counter width: $clog2(DEPTH). It compares against DEPTH-1, so DEPTH need
//     not be a power of two.
//   Reset during FLUSH: aborts immediately to IDLE with all valid bits clear.
// TESTING
//   1. After reset, read wl=16'h0001 tag_in=4'h3 -> next cycle rd_valid=1,
//      valid_out=0, hit=0, wl_err=0.
//   2. Write wl=16'h0020 tag=4'hA data=8'h5C -> echo A/5C, hit=1. Then read
//      wl=16'h0020 with tag_in=4'hA -> 5C, hit=1. With tag_in=4'hB -> hit=0,
//      valid_out=1.
//   3. req with wl=16'h0000 and with wl=16'h0011 (both we=1) -> wl_err=1,
//      outputs 0. Later reads of entries 0 and 4 show valid_out=0.
//   4. Fill all 16 entries, pulse flush -> busy high for exactly 16 cycles.
//      A write issued mid-flush has no effect. After busy drops, all reads
//      give valid_out=0, and data_out still equals the old data.
//   5. flush and req asserted in the same cycle -> no rd_valid; busy=1 next
//      cycle.
//   6. Assert rst_n=0 at flush cycle 5 -> busy=0 and rd_valid=0 immediately,
//      all entries invalid. Repeat 1-4 with DEPTH=12, DATA_W=32, TAG_W=20.

Source files
------------

// File: rtl/sram_tag_data_array.sv
// sram_tag_data_array: one-hot addressed tag+data array with per-entry valid bits,
// registered read/echo port with tag-compare hit, and a sequenced invalidate-all engine.
`default_nettype none

module sram_tag_data_array #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [DEPTH-1:0]  wl,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              busy,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              hit,
  output logic              wl_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              onehot;
  logic              accept;
  logic              flush_last;

  // Encoder result is only meaningful when the wordline is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wl[i]) idx = idx | IDX_W'(i);
    end
  end

  assign onehot     = (wl != '0) && ((wl & (wl - DEPTH'(1))) == '0);
  assign accept     = (state == IDLE) && !flush && req;
  assign flush_last = (cnt == LAST_IDX);
  assign busy       = (state == FLUSH);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (flush) state_nx = FLUSH;
      FLUSH:   if (flush_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      rd_valid  <= 1'b0;
      tag_out   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      hit       <= 1'b0;
      wl_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_valid  <= accept;
      tag_out   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      hit       <= 1'b0;
      wl_err    <= 1'b0;

      if (state == FLUSH) begin
        valid[cnt] <= 1'b0;
        cnt        <= flush_last ? '0 : cnt + IDX_W'(1);
      end

      if (accept) begin
        if (!onehot) begin
          wl_err <= 1'b1;
        end else if (we) begin
          valid[idx] <= 1'b1;
          tag_out    <= tag_in;
          data_out   <= data_in;
          valid_out  <= 1'b1;
          hit        <= 1'b1;
        end else begin
          tag_out   <= tag_mem[idx];
          data_out  <= data_mem[idx];
          valid_out <= valid[idx];
          hit       <= valid[idx] && (tag_mem[idx] == tag_in);
        end
      end
    end
  end

  // Storage carries no reset; only the valid bits define entry state.
  always_ff @(posedge clk) begin
    if (accept && onehot && we) begin
      tag_mem[idx]  <= tag_in;
      data_mem[idx] <= data_in;
    end
  end

endmodule

`default_nettype wire
